// File: rtl/player_position.sv
// Two-team player vertical position tracker: synchronizes and debounces four buttons,
// derives a frame-start pulse from the raster counters and steps each player once per frame.
module player_position #(
   parameter int unsigned PLAYER_RADIUS   = 25,
   parameter int unsigned STEP            = 4,
   parameter int unsigned DEBOUNCE_CYCLES = 250000,
   parameter int unsigned INIT_POS        = 275,
   parameter int unsigned Y_MIN           = 35,
   parameter int unsigned Y_MAX           = 514
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [9:0] x,
   input  logic [9:0] y,
   input  logic       t1_up,
   input  logic       t1_down,
   input  logic       t2_up,
   input  logic       t2_down,
   output logic [9:0] team1_ver_pos,
   output logic [9:0] team2_ver_pos,
   output logic       frame_tick
);

   localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [10:0] TOP    = 11'(Y_MIN + PLAYER_RADIUS);
   localparam logic [10:0] BOT    = 11'(Y_MAX - PLAYER_RADIUS);
   localparam logic [10:0] STEP_W = 11'(STEP);

   // Button order: [0] t1_up, [1] t1_down, [2] t2_up, [3] t2_down
   logic [3:0]       raw;
   logic [3:0]       sync1;
   logic [3:0]       sync2;
   logic [3:0]       db;
   logic [CNT_W-1:0] cnt [4];

   logic             f;
   logic             f_prev;
   logic [9:0]       next1;
   logic [9:0]       next2;

   assign raw = {t2_down, t2_up, t1_down, t1_up};
   assign f   = (x == '0) && (y == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
      end
   end

   // A change is accepted on the DEBOUNCE_CYCLES-th consecutive mismatching sample.
   always_ff @(posedge clk) begin
      if (rst) begin
         db <= '0;
         for (int unsigned i = 0; i < 4; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < 4; i++) begin
            if (sync2[i] == db[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == CNT_LAST) begin
               db[i]  <= ~db[i];
               cnt[i] <= '0;
            end else begin
               cnt[i] <= cnt[i] + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         f_prev     <= 1'b0;
         frame_tick <= 1'b0;
      end else begin
         f_prev     <= f;
         frame_tick <= f & ~f_prev;
      end
   end

   function automatic logic [9:0] step_pos(input logic [9:0] pos, input logic up, input logic dn);
      logic [10:0] p;
      p = {1'b0, pos};
      if (up && !dn) begin
         p = (p < TOP + STEP_W) ? TOP : p - STEP_W;
      end else if (dn && !up) begin
         p = (p + STEP_W > BOT) ? BOT : p + STEP_W;
      end
      return p[9:0];
   endfunction

   always_comb begin
      next1 = step_pos(team1_ver_pos, db[0], db[1]);
      next2 = step_pos(team2_ver_pos, db[2], db[3]);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         team1_ver_pos <= 10'(INIT_POS);
         team2_ver_pos <= 10'(INIT_POS);
      end else if (frame_tick) begin
         team1_ver_pos <= next1;
         team2_ver_pos <= next2;
      end
   end

endmodule

// File: tb/tb_player_position.sv
// Bench for player_position: directed scenarios plus randomized buttons/raster checked
// against a window-based behavioural model of debounce, frame pulse and clamped stepping.
module tb_player_position;

   localparam int D    = 4;
   localparam int STEP = 4;
   localparam int TOP  = 60;
   localparam int BOT  = 489;
   localparam int INIT = 275;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [9:0] x = '0;
   logic [9:0] y = '0;
   logic       t1_up = 1'b0;
   logic       t1_down = 1'b0;
   logic       t2_up = 1'b0;
   logic       t2_down = 1'b0;
   logic       b2_up = 1'b0;
   logic [9:0] team1_ver_pos;
   logic [9:0] team2_ver_pos;
   logic       frame_tick;
   logic [9:0] p62_team1;
   logic [9:0] p62_team2;
   logic       p62_tick;

   always #5 clk = ~clk;

   player_position #(.STEP(STEP), .DEBOUNCE_CYCLES(D)) dut (
      .clk(clk), .rst(rst), .x(x), .y(y),
      .t1_up(t1_up), .t1_down(t1_down), .t2_up(t2_up), .t2_down(t2_down),
      .team1_ver_pos(team1_ver_pos), .team2_ver_pos(team2_ver_pos), .frame_tick(frame_tick)
   );

   // Second instance starting at 62 to exercise the top clamp from an off-grid position.
   player_position #(.STEP(STEP), .DEBOUNCE_CYCLES(D), .INIT_POS(62)) dut62 (
      .clk(clk), .rst(rst), .x(x), .y(y),
      .t1_up(b2_up), .t1_down(1'b0), .t2_up(1'b0), .t2_down(1'b0),
      .team1_ver_pos(p62_team1), .team2_ver_pos(p62_team2), .frame_tick(p62_tick)
   );

   int         total = 0;
   int         bad = 0;
   int         ticks = 0;
   int         m_pos [2];
   bit         m_tick;
   bit         m_fprev;
   bit [3:0]   m_db;
   bit [3:0]   rd1;
   bit [3:0]   rd2;
   logic [3:0] hist [$];
   int         fresh [4];

   function automatic int move(int p, bit up, bit dn);
      if (up && !dn) return (p - STEP < TOP) ? TOP : p - STEP;
      if (dn && !up) return (p + STEP > BOT) ? BOT : p + STEP;
      return p;
   endfunction

   task automatic model_reset();
      m_pos[0] = INIT;
      m_pos[1] = INIT;
      m_tick = 0;
      m_fprev = 0;
      m_db = '0;
      rd1 = '0;
      rd2 = '0;
      hist.delete();
      for (int b = 0; b < 4; b++) fresh[b] = 0;
   endtask

   task automatic model_edge();
      bit [3:0] raw;
      bit       f;
      raw = {t2_down, t2_up, t1_down, t1_up};
      if (rst) begin
         model_reset();
      end else begin
         if (m_tick) begin
            m_pos[0] = move(m_pos[0], m_db[0], m_db[1]);
            m_pos[1] = move(m_pos[1], m_db[2], m_db[3]);
         end
         f = (x == 0) && (y == 0);
         m_tick = f && !m_fprev;
         m_fprev = f;
         // debouncer sees the raw value from two edges back
         hist.push_back(rd2);
         if (hist.size() > D) void'(hist.pop_front());
         for (int b = 0; b < 4; b++) begin
            bit all_diff;
            fresh[b]++;
            all_diff = (fresh[b] >= D);
            if (all_diff)
               for (int k = 0; k < D; k++)
                  if (hist[hist.size() - 1 - k][b] == m_db[b]) all_diff = 0;
            if (all_diff) begin
               m_db[b] = ~m_db[b];
               fresh[b] = 0;
            end
         end
         rd2 = rd1;
         rd1 = raw;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      model_edge();
      #1;
      check("tick", 32'(frame_tick), 32'(m_tick));
      check("pos1", 32'(team1_ver_pos), 32'(m_pos[0]));
      check("pos2", 32'(team2_ver_pos), 32'(m_pos[1]));
      ticks += int'(frame_tick);
   endtask

   task automatic idle(input int n);
      x = 10'd1;
      y = '0;
      repeat (n) cyc();
   endtask

   task automatic frame();
      x = '0;
      y = '0;
      cyc();
      cyc();
      x = 10'd1;
      cyc();
   endtask

   initial begin
      int hold;
      model_reset();

      // reset with x=y=0 already present
      rst = 1'b1; x = '0; y = '0;
      cyc();
      cyc();
      check("rst_pos1", 32'(team1_ver_pos), 275);
      check("rst_pos2", 32'(team2_ver_pos), 275);
      check("rst_tick", 32'(frame_tick), 0);
      rst = 1'b0;
      ticks = 0;
      cyc();
      check("tick_after_rst", 32'(frame_tick), 1);
      repeat (9) cyc();
      check("single_pulse", 32'(ticks), 1);

      // steady down on team 1
      t1_down = 1'b1;
      idle(8);
      frame();
      check("down_f1", 32'(team1_ver_pos), 279);
      frame();
      check("down_f2", 32'(team1_ver_pos), 283);
      frame();
      check("down_f3", 32'(team1_ver_pos), 287);
      check("down_t2", 32'(team2_ver_pos), 275);
      t1_down = 1'b0;
      idle(8);

      // 3-cycle glitch on t2_up is rejected
      t2_up = 1'b1;
      repeat (3) cyc();
      t2_up = 1'b0;
      idle(8);
      frame();
      check("glitch_t2", 32'(team2_ver_pos), 275);

      // drive toward the clamps
      t1_up = 1'b1;
      t2_down = 1'b1;
      idle(8);
      repeat (53) frame();
      check("run_t1", 32'(team1_ver_pos), 75);
      check("run_t2", 32'(team2_ver_pos), 487);
      t2_down = 1'b0;
      idle(8);
      repeat (3) frame();
      check("near_top_t1", 32'(team1_ver_pos), 63);
      check("hold_t2", 32'(team2_ver_pos), 487);
      check("p62_start", 32'(p62_team1), 62);
      b2_up = 1'b1;
      t2_down = 1'b1;
      idle(8);
      frame();
      check("clamp_top_t1", 32'(team1_ver_pos), 60);
      check("clamp_bot_t2", 32'(team2_ver_pos), 489);
      check("clamp_p62", 32'(p62_team1), 60);
      frame();
      check("stay_top_t1", 32'(team1_ver_pos), 60);
      check("stay_bot_t2", 32'(team2_ver_pos), 489);
      check("stay_p62", 32'(p62_team1), 60);
      b2_up = 1'b0;
      t2_down = 1'b0;

      // both directions on team 1 hold position
      t1_up = 1'b0;
      t1_down = 1'b1;
      idle(8);
      frame();
      check("leave_top", 32'(team1_ver_pos), 64);
      t1_up = 1'b1;
      idle(8);
      frame();
      check("both_hold", 32'(team1_ver_pos), 64);

      // reset coinciding with the frame_tick edge
      t1_up = 1'b0;
      idle(8);
      x = '0; y = '0;
      cyc();
      check("tick_before_rst", 32'(frame_tick), 1);
      rst = 1'b1;
      cyc();
      check("rst_wins_pos1", 32'(team1_ver_pos), 275);
      check("rst_wins_tick", 32'(frame_tick), 0);
      rst = 1'b0;
      t1_down = 1'b0;
      idle(4);

      // randomized buttons, raster and occasional reset
      hold = 0;
      for (int c = 0; c < 1500; c++) begin
         if (hold == 0) begin
            {t2_down, t2_up, t1_down, t1_up} = 4'($urandom);
            hold = int'($urandom_range(1, 14));
         end
         hold--;
         if (c % 20 < 2) begin
            x = '0;
            y = '0;
         end else begin
            x = 10'($urandom_range(0, 799));
            y = 10'($urandom_range(1, 524));
         end
         rst = ($urandom_range(0, 299) == 0);
         cyc();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
